range_stream_tx: RTL
====================

Name: range_stream_tx

Overview:
- Transmit end of the go/data/finish sample-stream protocol consumed by the team's range-finding blocks.
- Host loads up to DEPTH samples into a local buffer, then pulses start.
- Block then emits one framed burst: go with the first sample, remaining samples, then finish.
- Also provides the expected range (max−min) of the loaded samples, and an abort path that emits the go+finish error frame.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, buffer capacity in samples (≥1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  host offers load_data this cycle.
- load_data  in  WIDTH  sample to append.
- load_ready  out  1  buffer accepts a sample this cycle.
- clear  in  1  empty the buffer (honoured only in IDLE).
- start  in  1  begin transmission of buffered samples.
- abort  in  1  terminate an active transmission with an error frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after a normal finish frame.
- aborted  out  1  one-cycle pulse after an error frame.
- count  out  $clog2(DEPTH+1)  number of buffered samples.
- expected_range  out  WIDTH  max−min of buffered samples; 0 when count=0.
- data_out  out  WIDTH  stream sample to consumer data_in.
- go  out  1  stream start strobe.
- finish  out  1  stream end strobe.

Behaviour:
- Reset (reset=0, async): state IDLE, count=0, running min/max=0, index=0.
  - Outputs at reset: go=0, finish=0, data_out=0, done=0, aborted=0, busy=0, load_ready=1, expected_range=0.
- All stream outputs come from registered state/index/buffer only. There is no combinational input→stream path.
- Load handshake:
  - load_ready = (state==IDLE) && (count<DEPTH) && !start && !clear.
  - On load_valid&&load_ready: buf[count]<=load_data; count++.
  - First sample sets min=max=sample. Later samples update min/max (unsigned compare).
  - When full, load_valid is ignored; there is no overwrite.
- clear in IDLE: count<=0, min<=0, max<=0. clear wins over simultaneous start and load.
- start:
  - In IDLE with count≥1: next state GO.
  - In IDLE with count=0: ignored, no pulse.
  - Outside IDLE: ignored.
- FSM states: IDLE, GO, STREAM, FIN, ERR.
  - GO (1 cycle): go=1, finish=0, data_out=buf[0]. Next state STREAM if count≥2, else FIN.
  - STREAM: go=0, finish=0, data_out=buf[index] for index=1..count−1, one per cycle. After index=count−1, next state FIN.
  - FIN (1 cycle): finish=1, go=0, data_out holds buf[count−1]. A repeat of the last sample cannot change the consumer's min/max. Next state IDLE; done=1 during the first IDLE cycle.
  - ERR (1 cycle): go=1, finish=1, data_out=0. Next state IDLE; aborted=1 during the first IDLE cycle.
- abort:
  - Sampled in GO or STREAM: next state ERR, and remaining samples are not sent.
  - In FIN: ignored; the normal finish completes.
  - In IDLE: ignored.
- Outside frames, go=finish=0 and data_out=0.
- Burst length: N samples occupy N+1 cycles from go to finish inclusive. start→go latency is 1 cycle.
- The buffer and count persist after transmission. start again replays the same burst.
- expected_range = max−min, WIDTH bits, never negative by construction.
- Reset asserted mid-burst: immediate return to IDLE, go/finish low, buffer emptied.

Decomposition:
- Shared package:
  - state enum (IDLE, GO, STREAM, FIN, ERR) as logic [2:0].
  - Common stream frame typedef {go, finish, data}, reused by the range-finding receive blocks.
- One sub-module, range_stream_buf: DEPTH×WIDTH register array with append, count and running min/max.
- Top module holds the FSM and the read index.

Test Plan:
- Load 5,3,9 then start → cycle+1 go=1/data=5; then data=3, then 9; then finish=1/data=9; then done=1. expected_range=6 throughout.
- Load single sample 42, start → go=1/data=42 for one cycle, next cycle finish=1/data=42, then done; expected_range=0.
- Load DEPTH=8 samples → load_ready falls after the 8th. A 9th load_valid is not stored; count=8.
- Load 1,2,3,4, start, assert abort during the data=2 cycle → next cycle go=1,finish=1,data=0; then aborted=1; samples 3,4 never appear.
- start with count=0 → no go, busy stays 0. clear and start in the same cycle with count=3 → count=0, no transmission.
- Drive reset low mid-STREAM → go/finish/data_out go to 0 immediately and count=0. After reset release, load 7 and start → normal burst.

Source files
------------

// File: rtl/range_stream_tx_pkg.sv
// Shared types for the go/data/finish sample stream: FSM state encoding and the
// stream frame record used by the transmit and range-finding receive blocks.
package range_stream_tx_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GO     = 3'd1,
    STREAM = 3'd2,
    FIN    = 3'd3,
    ERR    = 3'd4
  } state_e;

  typedef struct packed {
    logic               go;
    logic               finish;
    logic [FRAME_W-1:0] data;
  } stream_frame_t;

endpackage

// File: rtl/range_stream_tx_if.sv
// Host load/control and consumer stream signals of range_stream_tx.
interface range_stream_tx_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             clear;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] expected_range;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;

  modport master (
    output load_valid, load_data, clear, start, abort,
    input  load_ready, busy, done, aborted, count, expected_range,
           data_out, go, finish
  );

  modport slave (
    input  load_valid, load_data, clear, start, abort,
    output load_ready, busy, done, aborted, count, expected_range,
           data_out, go, finish
  );
endinterface

// File: rtl/range_stream_tx_buf.sv
// Sample buffer: append-only register array with fill count and running
// unsigned min/max of the stored samples.
module range_stream_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_append,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH-1:0] o_max
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;

  // The caller only appends while count < DEPTH, so the write index never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
    end else if (i_append) begin
      r_mem[r_count[IDX_W-1:0]] <= i_data;
      r_count <= r_count + 1'b1;
      if (r_count == '0) begin
        r_min <= i_data;
        r_max <= i_data;
      end else begin
        if (i_data < r_min) r_min <= i_data;
        if (i_data > r_max) r_max <= i_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_count   = r_count;
  assign o_min     = r_min;
  assign o_max     = r_max;
endmodule

// File: rtl/range_stream_tx.sv
// Transmit side of the go/data/finish stream: buffers host samples, replays them
// as one framed burst on start, and emits a go+finish error frame on abort.
module range_stream_tx
  import range_stream_tx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  range_stream_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_GO     = GO;
  localparam logic [2:0] ST_STREAM = STREAM;
  localparam logic [2:0] ST_FIN    = FIN;
  localparam logic [2:0] ST_ERR    = ERR;

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  logic             r_aborted;

  logic             w_idle;
  logic             w_load_ready;
  logic             w_append;
  logic             w_clear;
  logic [CNT_W-1:0] w_count;
  logic [WIDTH-1:0] w_min;
  logic [WIDTH-1:0] w_max;
  logic [WIDTH-1:0] w_rd_data;
  logic [IDX_W-1:0] w_last_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_go;
  logic             w_finish;
  logic [WIDTH-1:0] w_data;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_load_ready = w_idle && (w_count < CNT_W'(DEPTH)) && !bus.start && !bus.clear;
  assign w_append     = bus.load_valid && w_load_ready;
  assign w_clear      = w_idle && bus.clear;
  assign w_last_idx   = IDX_W'(w_count - 1'b1);

  range_stream_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_append  (w_append),
    .i_data    (bus.load_data),
    .i_clear   (w_clear),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_min     (w_min),
    .o_max     (w_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= (r_state == ST_FIN);
      r_aborted <= (r_state == ST_ERR);
      case (r_state)
        ST_IDLE:
          if (bus.start && !bus.clear && (w_count != '0)) r_state <= ST_GO;
        ST_GO: begin
          r_idx <= IDX_W'(1);
          if (bus.abort)                  r_state <= ST_ERR;
          else if (w_count > CNT_W'(1))   r_state <= ST_STREAM;
          else                            r_state <= ST_FIN;
        end
        ST_STREAM:
          if (bus.abort)                  r_state <= ST_ERR;
          else if (r_idx == w_last_idx)   r_state <= ST_FIN;
          else                            r_idx   <= r_idx + 1'b1;
        ST_FIN:  r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIN re-presents the last sample so the consumer's min/max stays unchanged.
  always_comb begin
    w_rd_idx = r_idx;
    if (r_state == ST_GO)       w_rd_idx = '0;
    else if (r_state == ST_FIN) w_rd_idx = w_last_idx;
  end

  always_comb begin
    w_go     = 1'b0;
    w_finish = 1'b0;
    w_data   = '0;
    case (r_state)
      ST_GO: begin
        w_go   = 1'b1;
        w_data = w_rd_data;
      end
      ST_STREAM: w_data = w_rd_data;
      ST_FIN: begin
        w_finish = 1'b1;
        w_data   = w_rd_data;
      end
      ST_ERR: begin
        w_go     = 1'b1;
        w_finish = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.load_ready     = w_load_ready;
  assign bus.busy           = !w_idle;
  assign bus.done           = r_done;
  assign bus.aborted        = r_aborted;
  assign bus.count          = w_count;
  assign bus.expected_range = w_max - w_min;
  assign bus.data_out       = w_data;
  assign bus.go             = w_go;
  assign bus.finish         = w_finish;
endmodule
